// File: rtl/neo_pkg.sv
// Shared NEO constants and spike-detector state encoding.
// Parameter defaults are reused by the NEO energy block, this detector and their benches.
package neo_pkg;

  localparam int NEO_W          = 8;
  localparam int NEO_TRAIN_LOG2 = 4;
  localparam int NEO_K          = 4;
  localparam int NEO_REFRACT    = 3;

  typedef enum logic [1:0] {
    ST_TRAIN   = 2'd0,
    ST_DETECT  = 2'd1,
    ST_REFRACT = 2'd2
  } state_e;

endpackage

// File: rtl/neo_thr_calc.sv
// Threshold from the training sum: min((sum >> TRAIN_LOG2) * K, 2^W-1).
// Combinational, no latency; no flow control (the caller registers the result).
module neo_thr_calc
  import neo_pkg::*;
#(
  parameter int W          = NEO_W,
  parameter int TRAIN_LOG2 = NEO_TRAIN_LOG2,
  parameter int K          = NEO_K
) (
  input  logic [W+TRAIN_LOG2-1:0] sum,
  output logic [W-1:0]            thr
);

  // Room for the mean times a 4-bit multiplier without wrap.
  localparam int PW = W + TRAIN_LOG2 + 4;
  localparam logic [PW-1:0] MAXV = {{(PW-W){1'b0}}, {W{1'b1}}};

  logic [PW-1:0] prod;

  always_comb begin
    prod = PW'(sum >> TRAIN_LOG2) * PW'(K);
    thr  = (prod > MAXV) ? {W{1'b1}} : prod[W-1:0];
  end

endmodule

// File: rtl/neo_spike_detector.sv
// Learns a K x mean noise threshold, then flags samples above it with a refractory gap.
// Latency 1 cycle (all outputs registered); no backpressure, one sample accepted per cycle.
module neo_spike_detector
  import neo_pkg::*;
#(
  parameter int W          = NEO_W,
  parameter int TRAIN_LOG2 = NEO_TRAIN_LOG2,
  parameter int K          = NEO_K,
  parameter int REFRACT    = NEO_REFRACT,
  parameter int IDX_W      = 8,
  parameter int CNT_W      = 8
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             retrain,
  output logic [W-1:0]     threshold,
  output logic             thr_ready,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_index,
  output logic [CNT_W-1:0] spike_count,
  output logic             busy_train
);

  localparam int AW = W + TRAIN_LOG2;
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  localparam logic [TRAIN_LOG2-1:0] TCNT_ONE  = 1;
  localparam logic [TRAIN_LOG2-1:0] TCNT_LAST = '1;
  localparam logic [IDX_W-1:0]      IDX_ONE   = 1;
  localparam logic [CNT_W-1:0]      CNT_ONE   = 1;
  localparam logic [RW-1:0]         REFR_ONE  = 1;
  localparam logic [RW-1:0]         REFR_INIT = RW'(REFRACT);

  state_e                state_q, state_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic [TRAIN_LOG2-1:0] tcnt_q, tcnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [W-1:0]          threshold_q, threshold_d;
  logic                  thr_ready_q, thr_ready_d;
  logic                  spike_valid_q, spike_valid_d;
  logic [IDX_W-1:0]      spike_index_q, spike_index_d;
  logic [CNT_W-1:0]      spike_count_q, spike_count_d;
  logic                  busy_train_q, busy_train_d;
  logic [RW-1:0]         refr_q, refr_d;

  logic [AW-1:0]         acc_sum;
  logic [W-1:0]          thr_new;

  always_comb acc_sum = acc_q + AW'(in_data);

  neo_thr_calc #(
    .W          (W),
    .TRAIN_LOG2 (TRAIN_LOG2),
    .K          (K)
  ) u_thr_calc (
    .sum (acc_sum),
    .thr (thr_new)
  );

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    tcnt_d        = tcnt_q;
    idx_d         = idx_q;
    threshold_d   = threshold_q;
    thr_ready_d   = thr_ready_q;
    spike_valid_d = 1'b0;
    spike_index_d = spike_index_q;
    spike_count_d = spike_count_q;
    busy_train_d  = busy_train_q;
    refr_d        = refr_q;

    if (in_valid) idx_d = idx_q + IDX_ONE;

    // Retrain takes priority; a coincident sample opens the new training window.
    if (retrain) begin
      state_d       = ST_TRAIN;
      thr_ready_d   = 1'b0;
      busy_train_d  = 1'b1;
      spike_count_d = '0;
      refr_d        = '0;
      acc_d         = in_valid ? AW'(in_data) : '0;
      tcnt_d        = in_valid ? TCNT_ONE : '0;
    end else if (in_valid) begin
      case (state_q)
        ST_TRAIN: begin
          if (tcnt_q == TCNT_LAST) begin
            threshold_d  = thr_new;
            thr_ready_d  = 1'b1;
            busy_train_d = 1'b0;
            state_d      = ST_DETECT;
            acc_d        = '0;
            tcnt_d       = '0;
          end else begin
            acc_d  = acc_sum;
            tcnt_d = tcnt_q + TCNT_ONE;
          end
        end
        ST_DETECT: begin
          if (in_data > threshold_q) begin
            spike_valid_d = 1'b1;
            spike_index_d = idx_q;
            if (spike_count_q != {CNT_W{1'b1}}) spike_count_d = spike_count_q + CNT_ONE;
            refr_d = REFR_INIT;
            if (REFRACT > 0) state_d = ST_REFRACT;
          end
        end
        ST_REFRACT: begin
          refr_d = refr_q - REFR_ONE;
          if (refr_q == REFR_ONE) state_d = ST_DETECT;
        end
        default: state_d = ST_TRAIN;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q       <= ST_TRAIN;
      acc_q         <= '0;
      tcnt_q        <= '0;
      idx_q         <= '0;
      threshold_q   <= '0;
      thr_ready_q   <= 1'b0;
      spike_valid_q <= 1'b0;
      spike_index_q <= '0;
      spike_count_q <= '0;
      busy_train_q  <= 1'b1;
      refr_q        <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      tcnt_q        <= tcnt_d;
      idx_q         <= idx_d;
      threshold_q   <= threshold_d;
      thr_ready_q   <= thr_ready_d;
      spike_valid_q <= spike_valid_d;
      spike_index_q <= spike_index_d;
      spike_count_q <= spike_count_d;
      busy_train_q  <= busy_train_d;
      refr_q        <= refr_d;
    end
  end

  assign threshold   = threshold_q;
  assign thr_ready   = thr_ready_q;
  assign spike_valid = spike_valid_q;
  assign spike_index = spike_index_q;
  assign spike_count = spike_count_q;
  assign busy_train  = busy_train_q;

endmodule

// File: tb/tb_neo_spike_detector.sv
// Bench for neo_spike_detector: vector table plus hand sequences, spike indices via a queue.
// A second instance with a 2-bit counter shares the stimulus to exercise count saturation.
module tb_neo_spike_detector;

  logic       Clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       retrain;

  logic [7:0] threshold, spike_index, spike_count;
  logic       thr_ready, spike_valid, busy_train;
  logic [7:0] c2_threshold, c2_spike_index;
  logic [1:0] c2_spike_count;
  logic       c2_thr_ready, c2_spike_valid, c2_busy_train;

  int errors = 0;
  int checks = 0;
  logic [7:0] ix;
  logic [7:0] sb_q[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       spk;
    logic [7:0] cnt;
    logic [7:0] thr;
    logic       rdy;
  } vec_t;
  vec_t tbl[$];

  always #5 Clk = ~Clk;

  neo_spike_detector #(.W(8), .TRAIN_LOG2(4), .K(4), .REFRACT(3), .IDX_W(8), .CNT_W(8)) dut (
    .Clk(Clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .retrain(retrain),
    .threshold(threshold), .thr_ready(thr_ready), .spike_valid(spike_valid),
    .spike_index(spike_index), .spike_count(spike_count), .busy_train(busy_train)
  );

  neo_spike_detector #(.W(8), .TRAIN_LOG2(4), .K(4), .REFRACT(3), .IDX_W(8), .CNT_W(2)) dut_c2 (
    .Clk(Clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .retrain(retrain),
    .threshold(c2_threshold), .thr_ready(c2_thr_ready), .spike_valid(c2_spike_valid),
    .spike_index(c2_spike_index), .spike_count(c2_spike_count), .busy_train(c2_busy_train)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle; an expected spike pushes its index, the DUT pulse pops it.
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic spk);
    logic [7:0] exp_i;
    in_valid = v;
    in_data  = d;
    retrain  = r;
    if (spk) sb_q.push_back(ix);
    if (v) ix = ix + 8'd1;
    @(posedge Clk);
    #1;
    chk("spike_valid", {31'd0, spike_valid}, {31'd0, spk});
    if (spike_valid === 1'b1 && sb_q.size() > 0) begin
      exp_i = sb_q.pop_front();
      chk("spike_index", {24'd0, spike_index}, {24'd0, exp_i});
    end else if (spk && sb_q.size() > 0) begin
      void'(sb_q.pop_front());
    end
    in_valid = 1'b0;
    retrain  = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd200;
    retrain  = 1'b0;
    @(posedge Clk);
    #1;
    chk("rst_threshold",   {24'd0, threshold},   32'd0);
    chk("rst_thr_ready",   {31'd0, thr_ready},   32'd0);
    chk("rst_spike_valid", {31'd0, spike_valid}, 32'd0);
    chk("rst_spike_index", {24'd0, spike_index}, 32'd0);
    chk("rst_spike_count", {24'd0, spike_count}, 32'd0);
    chk("rst_busy_train",  {31'd0, busy_train},  32'd1);
    chk("rst_c2_count",    {30'd0, c2_spike_count}, 32'd0);
    reset    = 1'b1;
    in_valid = 1'b0;
    ix       = 8'd0;
    sb_q.delete();
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic spk,
                     input logic [7:0] cnt, input logic [7:0] thr, input logic rdy);
    vec_t e;
    e.v = v; e.d = d; e.spk = spk; e.cnt = cnt; e.thr = thr; e.rdy = rdy;
    tbl.push_back(e);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    retrain  = 1'b0;
    ix       = 8'd0;

    // Training on 16 x 10 -> 40, then strict compare and refractory behaviour.
    for (int i = 0; i < 15; i++) add(1'b1, 8'd10, 1'b0, 8'd0, 8'd0, 1'b0);
    add(1'b1, 8'd10,  1'b0, 8'd0, 8'd40, 1'b1);  // idx 15 completes training
    add(1'b0, 8'd99,  1'b0, 8'd0, 8'd40, 1'b1);  // idle
    add(1'b1, 8'd40,  1'b0, 8'd0, 8'd40, 1'b1);  // idx 16 equal, no spike
    add(1'b1, 8'd41,  1'b1, 8'd1, 8'd40, 1'b1);  // idx 17 spike
    for (int i = 0; i < 3; i++) add(1'b1, 8'd0, 1'b0, 8'd1, 8'd40, 1'b1);  // 18..20 refractory
    add(1'b1, 8'd50,  1'b1, 8'd2, 8'd40, 1'b1);  // idx 21 spike
    add(1'b1, 8'd50,  1'b0, 8'd2, 8'd40, 1'b1);  // idx 22 refractory
    add(1'b0, 8'd200, 1'b0, 8'd2, 8'd40, 1'b1);  // idle does not consume refractory
    add(1'b1, 8'd50,  1'b0, 8'd2, 8'd40, 1'b1);  // idx 23
    add(1'b1, 8'd50,  1'b0, 8'd2, 8'd40, 1'b1);  // idx 24
    add(1'b1, 8'd50,  1'b1, 8'd3, 8'd40, 1'b1);  // idx 25 spike

    do_reset();

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, 1'b0, tbl[i].spk);
      chk($sformatf("tbl%0d_count", i),     {24'd0, spike_count}, {24'd0, tbl[i].cnt});
      chk($sformatf("tbl%0d_threshold", i), {24'd0, threshold},   {24'd0, tbl[i].thr});
      chk($sformatf("tbl%0d_thr_ready", i), {31'd0, thr_ready},   {31'd0, tbl[i].rdy});
      chk($sformatf("tbl%0d_busy", i),      {31'd0, busy_train},  {31'd0, ~tbl[i].rdy});
    end
    chk("c2_count_sat3", {30'd0, c2_spike_count}, 32'd3);

    // Index wrap: quiet samples up to 255, then a spike at index 0.
    while (ix != 8'd0) step(1'b1, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'd50, 1'b0, 1'b1);
    chk("wrap_count",    {24'd0, spike_count},    32'd4);
    chk("wrap_c2_count", {30'd0, c2_spike_count}, 32'd3);
    for (int i = 0; i < 3; i++) step(1'b1, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'd60, 1'b0, 1'b1);
    chk("fifth_count",    {24'd0, spike_count},    32'd5);
    chk("fifth_c2_count", {30'd0, c2_spike_count}, 32'd3);

    // Retrain with a coincident sample while refractory; old threshold held.
    step(1'b1, 8'd20, 1'b1, 1'b0);
    chk("rt_thr_ready", {31'd0, thr_ready},      32'd0);
    chk("rt_busy",      {31'd0, busy_train},     32'd1);
    chk("rt_count",     {24'd0, spike_count},    32'd0);
    chk("rt_c2_count",  {30'd0, c2_spike_count}, 32'd0);
    chk("rt_threshold", {24'd0, threshold},      32'd40);
    for (int i = 0; i < 14; i++) step(1'b1, 8'd20, 1'b0, 1'b0);
    chk("rt14_thr_ready", {31'd0, thr_ready}, 32'd0);
    chk("rt14_threshold", {24'd0, threshold}, 32'd40);
    step(1'b1, 8'd20, 1'b0, 1'b0);
    chk("rt_new_threshold", {24'd0, threshold},  32'd80);
    chk("rt_new_ready",     {31'd0, thr_ready},  32'd1);
    chk("rt_new_busy",      {31'd0, busy_train}, 32'd0);
    step(1'b1, 8'd81, 1'b0, 1'b1);
    chk("rt_spike_count", {24'd0, spike_count}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'd80, 1'b0, 1'b0);
    chk("eq80_count", {24'd0, spike_count}, 32'd1);

    // Retrain without a sample; training values above the old threshold never fire.
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("rt2_thr_ready", {31'd0, thr_ready},   32'd0);
    chk("rt2_count",     {24'd0, spike_count}, 32'd0);
    chk("rt2_threshold", {24'd0, threshold},   32'd80);
    for (int i = 0; i < 16; i++) step(1'b1, 8'd100, 1'b0, 1'b0);
    chk("sat_threshold", {24'd0, threshold}, 32'd255);
    chk("sat_ready",     {31'd0, thr_ready}, 32'd1);
    step(1'b1, 8'd255, 1'b0, 1'b0);
    step(1'b1, 8'd255, 1'b0, 1'b0);
    chk("sat_count", {24'd0, spike_count}, 32'd0);

    // Reset in DETECT, then retrain from scratch and spike at index 16.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'd10, 1'b0, 1'b0);
    chk("post_rst_threshold", {24'd0, threshold}, 32'd40);
    step(1'b1, 8'd41, 1'b0, 1'b1);
    chk("post_rst_count", {24'd0, spike_count}, 32'd1);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
